stream_upsize_arb: RTL and testbench
====================================

// Module: stream_upsize_arb
// PURPOSE
//  Packet-level round-robin arbiter that shares one stream_upsize input port between N_SRC
//  narrow requester streams. Grants one source per packet and holds the grant until that
//  packet's last beat is accepted. Enforces a maximum packet length so one stalled source
//  cannot hold the upsizer forever. Sits directly upstream of stream_upsize; m_* drives its s_*.
// PARAMETERS
//  T_DATA_WIDTH  4   beat width, equal to stream_upsize T_DATA_WIDTH
//  N_SRC         4   number of requester streams, >=2
//  MAX_BEATS     16  max beats per granted packet before a forced last, >=1
// PORTS
//  clk          in   1                    clock
//  rst_n        in   1                    synchronous, active-low reset
//  s_data_i     in   [N_SRC][T_DATA_WIDTH] per-source beat data (unpacked array over N_SRC)
//  s_last_i     in   N_SRC                per-source last-beat flag
//  s_valid_i    in   N_SRC                per-source valid
//  s_ready_o    out  N_SRC                per-source ready
//  m_data_o     out  T_DATA_WIDTH         muxed data to upsizer
//  m_last_o     out  1                    muxed (or forced) last
//  m_valid_o    out  1                    muxed valid
//  m_ready_i    in   1                    upsizer ready
//  grant_o      out  N_SRC                one-hot current grant, 0 when idle
//  err_trunc_o  out  1                    1-cycle pulse on a forced-last beat
// BEHAVIOUR
//  - Reset: state=IDLE, grant_o=0, m_valid_o=0, s_ready_o=0, err_trunc_o=0, beat_cnt=0,
//    rr_ptr=N_SRC-1 (so after reset source 0 has the highest priority).
//  - FSM IDLE: if |s_valid_i, select the first valid source searching rr_ptr+1, rr_ptr+2, ...
//    modulo N_SRC. Register it in grant_o and go to BUSY. No beat is passed in IDLE.
//    Arbitration latency is 1 cycle, so a packet's first beat is visible on m_* at the
//    earliest one cycle after its s_valid rises.
//  - FSM BUSY, granted index g: m_data_o=s_data_i[g], m_valid_o=s_valid_i[g],
//    s_ready_o[g]=m_ready_i (combinational), all other s_ready_o=0.
//    A beat is accepted when m_valid_o & m_ready_i.
//  - beat_cnt (width $clog2(MAX_BEATS+1)) increments on each accepted beat and clears on
//    packet end. m_last_o = s_last_i[g] | (beat_cnt==MAX_BEATS-1).
//  - Packet end is an accepted beat with m_last_o=1. Then: rr_ptr<=g, grant_o<=0,
//    beat_cnt<=0, next state IDLE. Back-to-back packets therefore have a 1-cycle bubble.
//  - Forced last (beat_cnt==MAX_BEATS-1 and s_last_i[g]=0 on an accepted beat):
//    err_trunc_o=1 for exactly that cycle. The source's remaining beats re-arbitrate as a
//    new packet.
//  - Source drops s_valid while granted: the grant is held, m_valid_o=0, and no timeout applies.
//  - Held beat: m_data_o and m_last_o must be stable while m_valid_o=1 and m_ready_i=0.
//    This requires the source itself to obey the valid/ready stability rule.
//  - Reset mid-packet returns to the reset values on the next clk edge. The partial packet
//    is abandoned.
//  - Only one source is granted at a time. No beat from an ungranted source is ever accepted.
// CONFIGURATION
//  STREAM_UPSIZE_ARB_ID_EN defined:
//    - Adds output m_id_o [$clog2(N_SRC)-1:0], the binary index of g.
//    - m_id_o is valid whenever m_valid_o=1, is 0 in IDLE, and is 0 at reset.
//  STREAM_UPSIZE_ARB_ID_EN undefined:
//    - The port and its logic are absent. All other behaviour is identical.
// TESTING
//  1 After reset, src0 sends a 3-beat packet A0,A1,A2(last) with m_ready=1.
//    -> grant_o=0001 one cycle after valid; m_data A0,A1,A2 on consecutive cycles with
//       m_last on A2; grant_o=0 the next cycle.
//  2 All 4 sources hold 1-beat packets continuously.
//    -> grants go 0001,0010,0100,1000,0001, with one idle cycle between packets.
//  3 src2 sends a 20-beat packet with no last, MAX_BEATS=16.
//    -> m_last and err_trunc_o=1 on beat 16; beats 17-20 form a second grant; src2 is
//       re-granted only after other valid sources are served.
//  4 m_ready_i is toggled 1,0,0,1 during src1's packet.
//    -> s_ready_o[1] follows m_ready_i; m_data is held on stall cycles; no beat is
//       duplicated or dropped.
//  5 rst_n=0 asserted during beat 2 of a src3 packet.
//    -> grant_o=0, m_valid_o=0, s_ready_o=0 next cycle; first post-reset grant goes to
//       src0 if it is valid.
//  6 With STREAM_UPSIZE_ARB_ID_EN defined, repeat test 2.
//    -> m_id_o reads 0,1,2,3 in step with grant_o.

Source files
------------

// File: rtl/stream_upsize_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : stream_upsize_arb                                              |
// | Purpose  : Packet-level round-robin arbiter sharing one stream_upsize     |
// |            input between N_SRC narrow requester streams. One source is    |
// |            granted per packet; the grant is held until that packet's      |
// |            last beat is accepted. A packet longer than MAX_BEATS is cut   |
// |            with a forced last and flagged on err_trunc_o.                 |
// | Ports    : clk, rst_n (synchronous, active-low)                           |
// |            s_data_i/s_last_i/s_valid_i/s_ready_o : per-source streams     |
// |            m_data_o/m_last_o/m_valid_o/m_ready_i : to the upsizer         |
// |            grant_o     : one-hot current grant, 0 when idle               |
// |            err_trunc_o : pulse on an accepted forced-last beat            |
// |            m_id_o      : binary grant index (STREAM_UPSIZE_ARB_ID_EN)     |
// | Options  : define STREAM_UPSIZE_ARB_ID_EN to add the m_id_o output.       |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module stream_upsize_arb #(
    parameter int T_DATA_WIDTH = 4,
    parameter int N_SRC        = 4,
    parameter int MAX_BEATS    = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [T_DATA_WIDTH-1:0]       s_data_i [N_SRC],
    input  logic [N_SRC-1:0]              s_last_i,
    input  logic [N_SRC-1:0]              s_valid_i,
    output logic [N_SRC-1:0]              s_ready_o,
    output logic [T_DATA_WIDTH-1:0]       m_data_o,
    output logic                          m_last_o,
    output logic                          m_valid_o,
    input  logic                          m_ready_i,
    output logic [N_SRC-1:0]              grant_o,
`ifdef STREAM_UPSIZE_ARB_ID_EN
    output logic [$clog2(N_SRC)-1:0]      m_id_o,
`endif
    output logic                          err_trunc_o
);

    localparam int c_IDX_W = $clog2(N_SRC);
    localparam int c_CNT_W = $clog2(MAX_BEATS + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(MAX_BEATS - 1);
    localparam logic [c_IDX_W-1:0] c_RR_RESET = c_IDX_W'(N_SRC - 1);
    localparam logic [c_IDX_W:0]   c_N_WIDE   = (c_IDX_W + 1)'(N_SRC);
    localparam logic [N_SRC-1:0]   c_ONE      = N_SRC'(1);

    logic [0:0]          r_state;
    logic [N_SRC-1:0]    r_grant;
    logic [c_IDX_W-1:0]  r_gidx;
    logic [c_IDX_W-1:0]  r_rr_ptr;
    logic [c_CNT_W-1:0]  r_beat_cnt;

    logic [0:0]          w_state_nxt;
    logic [N_SRC-1:0]    w_grant_nxt;
    logic [c_IDX_W-1:0]  w_gidx_nxt;
    logic [c_IDX_W-1:0]  w_rr_ptr_nxt;
    logic [c_CNT_W-1:0]  w_beat_cnt_nxt;

    logic                w_busy;
    logic                w_force;
    logic                w_accept;
    logic                w_found;
    logic [c_IDX_W-1:0]  w_pick;
    logic [c_IDX_W:0]    w_cand;

    // Round-robin search: first valid source starting just after the last
    // served one. The candidate is one bit wider so rr_ptr+k cannot wrap
    // before the explicit modulo-N_SRC correction.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_cand  = '0;
        for (int k = 1; k <= N_SRC; k++) begin
            w_cand = {1'b0, r_rr_ptr} + (c_IDX_W + 1)'(k);
            if (w_cand >= c_N_WIDE) begin
                w_cand = w_cand - c_N_WIDE;
            end
            if (!w_found && s_valid_i[w_cand[c_IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_cand[c_IDX_W-1:0];
            end
        end
    end

    // Datapath mux. r_grant is all-zero in IDLE, so s_ready_o needs no gating.
    assign w_busy      = (r_state == S_BUSY);
    assign w_force     = (r_beat_cnt == c_LAST_CNT);
    assign m_data_o    = w_busy ? s_data_i[r_gidx] : '0;
    assign m_valid_o   = w_busy & s_valid_i[r_gidx];
    assign m_last_o    = w_busy & (s_last_i[r_gidx] | w_force);
    assign s_ready_o   = r_grant & {N_SRC{m_ready_i}};
    assign w_accept    = m_valid_o & m_ready_i;
    assign err_trunc_o = w_accept & w_force & ~s_last_i[r_gidx];
    assign grant_o     = r_grant;

`ifdef STREAM_UPSIZE_ARB_ID_EN
    assign m_id_o = w_busy ? r_gidx : '0;
`endif

    // Next-state logic
    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_gidx_nxt     = r_gidx;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_beat_cnt_nxt = r_beat_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_BUSY;
                    w_gidx_nxt  = w_pick;
                    w_grant_nxt = c_ONE << w_pick;
                end
            end
            S_BUSY: begin
                if (w_accept) begin
                    if (m_last_o) begin
                        // Packet end (real or forced): the served source
                        // becomes lowest priority for the next round.
                        w_state_nxt    = S_IDLE;
                        w_grant_nxt    = '0;
                        w_rr_ptr_nxt   = r_gidx;
                        w_beat_cnt_nxt = '0;
                    end else begin
                        w_beat_cnt_nxt = r_beat_cnt + c_CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_gidx     <= '0;
            r_rr_ptr   <= c_RR_RESET;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_gidx     <= w_gidx_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stream_upsize_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_stream_upsize_arb                                          |
// | Purpose  : Self-checking bench for stream_upsize_arb: a directed vector  |
// |            table, hand-written multi-cycle sequences (truncation, stall,|
// |            reset mid-packet) and randomized traffic compared against a  |
// |            packet-level reference model.                                 |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_stream_upsize_arb;

    localparam int N    = 4;
    localparam int W    = 4;
    localparam int MAXB = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  s_data [N];
    logic [N-1:0]  s_last;
    logic [N-1:0]  s_valid;
    logic [N-1:0]  s_ready;
    logic [W-1:0]  m_data;
    logic          m_last;
    logic          m_valid;
    logic          m_ready;
    logic [N-1:0]  grant;
    logic          err;
`ifdef STREAM_UPSIZE_ARB_ID_EN
    logic [1:0]    m_id;
`endif

    always #5 clk = ~clk;

    stream_upsize_arb #(.T_DATA_WIDTH(W), .N_SRC(N), .MAX_BEATS(MAXB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_data_i    (s_data),
        .s_last_i    (s_last),
        .s_valid_i   (s_valid),
        .s_ready_o   (s_ready),
        .m_data_o    (m_data),
        .m_last_o    (m_last),
        .m_valid_o   (m_valid),
        .m_ready_i   (m_ready),
        .grant_o     (grant),
`ifdef STREAM_UPSIZE_ARB_ID_EN
        .m_id_o      (m_id),
`endif
        .err_trunc_o (err)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: owner (-1 = nobody), beats taken so far, last served.
    int            own = -1;
    int            cnt = 0;
    int            ptr = N - 1;
    logic [N-1:0]  ex_rdy;

    // Inputs are set at posedge+1; this checks at posedge+2, advances the
    // model and returns at the next posedge+1.
    task automatic cyc();
        logic [N-1:0] e_gnt, e_rdy;
        logic         e_vld, e_lst, e_err, acc, found;
        int           c;
        #1;
        e_gnt = '0; e_rdy = '0; e_vld = 1'b0; e_lst = 1'b0; e_err = 1'b0;
        if (own >= 0) begin
            e_gnt = 4'(1) << own;
            e_vld = s_valid[own];
            e_lst = s_last[own] || (cnt == MAXB - 1);
            e_rdy = m_ready ? e_gnt : '0;
            e_err = e_vld && m_ready && (cnt == MAXB - 1) && !s_last[own];
        end
        chk("grant", 64'(grant), 64'(e_gnt));
        chk("m_valid", 64'(m_valid), 64'(e_vld));
        chk("s_ready", 64'(s_ready), 64'(e_rdy));
        chk("err_trunc", 64'(err), 64'(e_err));
        if (e_vld) begin
            chk("m_data", 64'(m_data), 64'(s_data[own]));
            chk("m_last", 64'(m_last), 64'(e_lst));
        end
`ifdef STREAM_UPSIZE_ARB_ID_EN
        chk("m_id", 64'(m_id), (own >= 0) ? 64'(own) : 64'(0));
`endif
        ex_rdy = e_rdy;
        acc    = e_vld && m_ready;
        if (!rst_n) begin
            own = -1; cnt = 0; ptr = N - 1;
        end else if (own < 0) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                c = (ptr + k) % N;
                if (!found && s_valid[c]) begin
                    found = 1'b1;
                    own   = c;
                end
            end
        end else if (acc) begin
            if (e_lst) begin
                ptr = own; own = -1; cnt = 0;
            end else begin
                cnt++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; s_valid = '0; s_last = '0; m_ready = 1'b1;
        cyc();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        r;
        logic [3:0]  vld, lst;
        logic [15:0] dat;
        logic        rdy;
        logic [3:0]  e_gnt;
        logic        e_vld;
        logic [3:0]  e_dat;
        logic        e_lst;
        logic [3:0]  e_rdy;
        logic        e_err;
    } vec_t;

    vec_t tbl [17];

    function automatic vec_t mk(input logic r, input logic [3:0] vld, input logic [3:0] lst,
                                input logic [15:0] dat, input logic rdy, input logic [3:0] eg,
                                input logic ev, input logic [3:0] ed, input logic el,
                                input logic [3:0] er, input logic ee);
        vec_t v;
        v.r = r; v.vld = vld; v.lst = lst; v.dat = dat; v.rdy = rdy;
        v.e_gnt = eg; v.e_vld = ev; v.e_dat = ed; v.e_lst = el; v.e_rdy = er; v.e_err = ee;
        return v;
    endfunction

    initial begin
        // 3-beat packet from src0 after reset, then all four sources with
        // continuous 1-beat packets (rotation with a bubble between grants).
        tbl[0]  = mk(0, 4'h0, 4'h0, 16'h0000, 1, 4'h0, 0, 4'h0, 0, 4'h0, 0);
        tbl[1]  = mk(1, 4'h1, 4'h0, 16'h0005, 1, 4'h0, 0, 4'h0, 0, 4'h0, 0);
        tbl[2]  = mk(1, 4'h1, 4'h0, 16'h0005, 1, 4'h1, 1, 4'h5, 0, 4'h1, 0);
        tbl[3]  = mk(1, 4'h1, 4'h0, 16'h0006, 1, 4'h1, 1, 4'h6, 0, 4'h1, 0);
        tbl[4]  = mk(1, 4'h1, 4'h1, 16'h0007, 1, 4'h1, 1, 4'h7, 1, 4'h1, 0);
        tbl[5]  = mk(1, 4'h0, 4'h0, 16'h0000, 1, 4'h0, 0, 4'h0, 0, 4'h0, 0);
        tbl[6]  = mk(0, 4'h0, 4'h0, 16'h0000, 1, 4'h0, 0, 4'h0, 0, 4'h0, 0);
        tbl[7]  = mk(1, 4'hF, 4'hF, 16'h4321, 1, 4'h0, 0, 4'h0, 0, 4'h0, 0);
        tbl[8]  = mk(1, 4'hF, 4'hF, 16'h4321, 1, 4'h1, 1, 4'h1, 1, 4'h1, 0);
        tbl[9]  = mk(1, 4'hF, 4'hF, 16'h4321, 1, 4'h0, 0, 4'h0, 0, 4'h0, 0);
        tbl[10] = mk(1, 4'hF, 4'hF, 16'h4321, 1, 4'h2, 1, 4'h2, 1, 4'h2, 0);
        tbl[11] = mk(1, 4'hF, 4'hF, 16'h4321, 1, 4'h0, 0, 4'h0, 0, 4'h0, 0);
        tbl[12] = mk(1, 4'hF, 4'hF, 16'h4321, 1, 4'h4, 1, 4'h3, 1, 4'h4, 0);
        tbl[13] = mk(1, 4'hF, 4'hF, 16'h4321, 1, 4'h0, 0, 4'h0, 0, 4'h0, 0);
        tbl[14] = mk(1, 4'hF, 4'hF, 16'h4321, 1, 4'h8, 1, 4'h4, 1, 4'h8, 0);
        tbl[15] = mk(1, 4'hF, 4'hF, 16'h4321, 1, 4'h0, 0, 4'h0, 0, 4'h0, 0);
        tbl[16] = mk(1, 4'hF, 4'hF, 16'h4321, 1, 4'h1, 1, 4'h1, 1, 4'h1, 0);

        rst_n = 1'b0; s_valid = '0; s_last = '0; m_ready = 1'b1;
        for (int j = 0; j < N; j++) s_data[j] = '0;
        @(posedge clk);
        #1;

        // ---- directed vector table ----
        for (int i = 0; i < 17; i++) begin
            rst_n = tbl[i].r; s_valid = tbl[i].vld; s_last = tbl[i].lst; m_ready = tbl[i].rdy;
            for (int j = 0; j < N; j++) s_data[j] = tbl[i].dat[j*4 +: 4];
            #1;
            chk($sformatf("tbl%0d.grant", i), 64'(grant), 64'(tbl[i].e_gnt));
            chk($sformatf("tbl%0d.m_valid", i), 64'(m_valid), 64'(tbl[i].e_vld));
            chk($sformatf("tbl%0d.s_ready", i), 64'(s_ready), 64'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d.err", i), 64'(err), 64'(tbl[i].e_err));
            if (tbl[i].e_vld) begin
                chk($sformatf("tbl%0d.m_data", i), 64'(m_data), 64'(tbl[i].e_dat));
                chk($sformatf("tbl%0d.m_last", i), 64'(m_last), 64'(tbl[i].e_lst));
            end
            cyc();
        end

        // ---- src2 20-beat packet without last: truncation at beat 16 ----
        do_reset();
        s_valid = 4'b0100; s_last = '0; s_data[2] = 4'h1;
        cyc();                                   // arbitration cycle
        for (int b = 1; b <= 16; b++) begin
            s_data[2] = 4'(b);
            if (b == 16) begin
                s_valid = 4'b0101; s_data[0] = 4'hF; s_last = 4'b0001;
            end
            #1;
            chk("trunc.grant", 64'(grant), 64'h4);
            chk("trunc.err", 64'(err), (b == 16) ? 64'h1 : 64'h0);
            chk("trunc.m_last", 64'(m_last), (b == 16) ? 64'h1 : 64'h0);
            cyc();
        end
        s_data[2] = 4'h1;                        // beat 17, held until granted
        #1; chk("trunc.idle", 64'(grant), 64'h0);
        cyc();
        #1; chk("trunc.src0_first", 64'(grant), 64'h1);
        cyc();
        s_valid = 4'b0100; s_last = '0;
        cyc();
        for (int b = 17; b <= 20; b++) begin
            s_data[2] = 4'(b);
            s_last[2] = (b == 20);
            #1;
            chk("trunc.regrant", 64'(grant), 64'h4);
            chk("trunc.err2", 64'(err), 64'h0);
            cyc();
        end
        s_valid = '0; s_last = '0;
        cyc();

        // ---- src1 packet with m_ready 1,0,0,1 ----
        do_reset();
        s_valid = 4'b0010; s_data[1] = 4'h8;
        cyc();
        #1; chk("stall.d8", 64'(m_data), 64'h8);
        cyc();
        s_data[1] = 4'h9; m_ready = 1'b0;
        #1; chk("stall.hold1", 64'(m_data), 64'h9); chk("stall.rdy1", 64'(s_ready), 64'h0);
        cyc();
        #1; chk("stall.hold2", 64'(m_data), 64'h9); chk("stall.rdy2", 64'(s_ready), 64'h0);
        cyc();
        m_ready = 1'b1;
        #1; chk("stall.d9", 64'(m_data), 64'h9); chk("stall.rdy3", 64'(s_ready), 64'h2);
        cyc();
        s_data[1] = 4'hA;
        #1; chk("stall.dA", 64'(m_data), 64'hA);
        cyc();
        s_data[1] = 4'hB; s_last = 4'b0010;
        #1; chk("stall.dB", 64'(m_data), 64'hB); chk("stall.last", 64'(m_last), 64'h1);
        cyc();
        s_valid = '0; s_last = '0;
        #1; chk("stall.end", 64'(grant), 64'h0);
        cyc();

        // ---- reset during beat 2 of a src3 packet ----
        do_reset();
        s_valid = 4'b1000; s_data[3] = 4'h3;
        cyc();
        cyc();
        s_data[3] = 4'h4; rst_n = 1'b0;
        cyc();
        rst_n = 1'b1; s_valid = 4'b1001; s_data[0] = 4'h2; s_last = 4'b0001;
        #1;
        chk("rst.grant", 64'(grant), 64'h0);
        chk("rst.m_valid", 64'(m_valid), 64'h0);
        chk("rst.s_ready", 64'(s_ready), 64'h0);
        cyc();
        #1; chk("rst.src0", 64'(grant), 64'h1);
        cyc();

        // ---- randomized traffic against the model ----
        do_reset();
        s_valid = '0; s_last = '0;
        for (int n = 0; n < 3000; n++) begin
            rst_n   = ($urandom % 400) != 0;
            m_ready = ($urandom % 4) != 0;
            cyc();
            for (int i = 0; i < N; i++) begin
                if (s_valid[i] && ex_rdy[i]) s_valid[i] = 1'b0;
                if (!s_valid[i] && ($urandom % 3) == 0) begin
                    s_valid[i] = 1'b1;
                    s_data[i]  = W'($urandom);
                    s_last[i]  = ($urandom % 6) == 0;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
